// File: rtl/miller_rx_ctrl.sv
// Receive-frame sequencer for the modified-Miller decoder chain (106 kb/s,
// fc/16 clock, 8 clocks per ETU). Arms the chain, waits for SoF, packs
// decoded bits LSB-first into bytes with odd-parity checking, and closes the
// frame on EoF, error, overflow or timeout with a held status code.
// All state changes on the falling edge of in_clk.
module miller_rx_ctrl #(
    parameter int SOF_TIMEOUT = 4096,
    parameter int GAP_MAX     = 24,
    parameter int MAX_BYTES   = 64,
    parameter int CW          = 13
) (
    input  logic       in_clk,
    input  logic       in_PoR,
    input  logic       in_start,
    input  logic       in_abort,
    input  logic       in_sof_detected,
    input  logic       in_bit_valid,
    input  logic       in_bit,
    input  logic       in_eof_detected,
    output logic       out_chain_rst,
    output logic       out_chain_en,
    output logic [7:0] out_byte,
    output logic       out_byte_valid,
    output logic       out_byte_perr,
    output logic       out_busy,
    output logic       out_done,
    output logic [2:0] out_status,
    output logic [6:0] out_nbytes
);

    localparam int GW = $clog2(GAP_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ARM      = 3'd1,
        S_WAIT_SOF = 3'd2,
        S_RECV     = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    localparam logic [2:0] ST_OK         = 3'd0;
    localparam logic [2:0] ST_SHORT      = 3'd1;
    localparam logic [2:0] ST_PARITY     = 3'd2;
    localparam logic [2:0] ST_INCOMPLETE = 3'd3;
    localparam logic [2:0] ST_OVERFLOW   = 3'd4;
    localparam logic [2:0] ST_SOF_TO     = 3'd5;
    localparam logic [2:0] ST_GAP_TO     = 3'd6;

    localparam logic [CW-1:0] SOF_LAST = CW'(SOF_TIMEOUT - 1);
    localparam logic [GW-1:0] GAP_LIM  = GW'(GAP_MAX);
    localparam logic [6:0]    BYTE_LIM = 7'(MAX_BYTES);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_sof_cnt;
    logic [GW-1:0] r_gap_cnt;
    logic [3:0]    r_bitcnt;
    logic [7:0]    r_shift;
    logic [6:0]    r_nbytes;
    logic          r_perr_sticky;

    logic          r_chain_rst;
    logic          r_chain_en;
    logic [7:0]    r_byte;
    logic          r_byte_valid;
    logic          r_byte_perr;
    logic          r_busy;
    logic          r_done;
    logic [2:0]    r_status;
    logic [6:0]    r_nbytes_out;

    logic          w_abort;
    logic          w_eof;
    logic          w_bit;
    logic          w_parity_slot;
    logic          w_overflow;
    logic          w_short;
    logic          w_perr;
    logic [2:0]    w_status;
    logic [6:0]    w_nbytes_fin;

    // Qualified events: EoF wins over a coincident bit strobe, abort only outside IDLE.
    always_comb begin
        w_abort       = in_abort && (r_state != S_IDLE);
        w_eof         = (r_state == S_RECV) && in_eof_detected;
        w_bit         = (r_state == S_RECV) && in_bit_valid && !in_eof_detected;
        w_parity_slot = (r_bitcnt == 4'd8);
        w_overflow    = w_bit && w_parity_slot && (r_nbytes == BYTE_LIM);
        w_short       = (r_nbytes == 7'd0) && (r_bitcnt == 4'd7);
        // Odd parity: error when the byte plus parity bit holds an even count of ones.
        w_perr        = ~(^{r_shift, in_bit});
    end

    // Next-state selection and the status/byte count to latch on entry to DONE.
    always_comb begin
        w_state_nxt  = r_state;
        w_status     = ST_OK;
        w_nbytes_fin = r_nbytes;
        if (w_abort) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_start) begin
                        w_state_nxt = S_ARM;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
                S_ARM: begin
                    w_state_nxt = S_WAIT_SOF;
                end
                S_WAIT_SOF: begin
                    // The SoF counter counts clocks since ARM, so the timeout
                    // lands exactly SOF_TIMEOUT clocks after ARM.
                    if (in_sof_detected) begin
                        w_state_nxt = S_RECV;
                    end else if (r_sof_cnt == SOF_LAST) begin
                        w_state_nxt = S_DONE;
                        w_status    = ST_SOF_TO;
                    end else begin
                        w_state_nxt = S_WAIT_SOF;
                    end
                end
                S_RECV: begin
                    if (w_eof) begin
                        w_state_nxt = S_DONE;
                        if (w_short) begin
                            w_status     = ST_SHORT;
                            w_nbytes_fin = 7'd1;
                        end else if ((r_bitcnt == 4'd0) && (r_nbytes != 7'd0)) begin
                            w_status = r_perr_sticky ? ST_PARITY : ST_OK;
                        end else begin
                            w_status = ST_INCOMPLETE;
                        end
                    end else if (w_overflow) begin
                        w_state_nxt = S_DONE;
                        w_status    = ST_OVERFLOW;
                    end else if (w_bit) begin
                        w_state_nxt = S_RECV;
                    end else if (r_gap_cnt == GAP_LIM) begin
                        w_state_nxt = S_DONE;
                        w_status    = ST_GAP_TO;
                    end else begin
                        w_state_nxt = S_RECV;
                    end
                end
                S_DONE: begin
                    w_state_nxt = S_IDLE;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // State register, bit/byte datapath and registered outputs decoded from the next state.
    always_ff @(negedge in_clk) begin
        if (in_PoR) begin
            r_state       <= S_IDLE;
            r_sof_cnt     <= '0;
            r_gap_cnt     <= '0;
            r_bitcnt      <= 4'd0;
            r_shift       <= 8'd0;
            r_nbytes      <= 7'd0;
            r_perr_sticky <= 1'b0;
            r_chain_rst   <= 1'b0;
            r_chain_en    <= 1'b0;
            r_byte        <= 8'd0;
            r_byte_valid  <= 1'b0;
            r_byte_perr   <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_status      <= 3'd0;
            r_nbytes_out  <= 7'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_chain_rst  <= (w_state_nxt == S_WAIT_SOF) || (w_state_nxt == S_RECV);
            r_chain_en   <= (w_state_nxt == S_WAIT_SOF) || (w_state_nxt == S_RECV);
            r_busy       <= (w_state_nxt == S_ARM) || (w_state_nxt == S_WAIT_SOF) ||
                            (w_state_nxt == S_RECV);
            r_done       <= (w_state_nxt == S_DONE);
            r_byte_valid <= 1'b0;
            r_byte_perr  <= 1'b0;
            if (w_state_nxt == S_DONE) begin
                r_status     <= w_status;
                r_nbytes_out <= w_nbytes_fin;
            end
            case (r_state)
                S_IDLE: begin
                    r_sof_cnt <= '0;
                end
                S_ARM: begin
                    r_shift       <= 8'd0;
                    r_bitcnt      <= 4'd0;
                    r_nbytes      <= 7'd0;
                    r_perr_sticky <= 1'b0;
                    r_gap_cnt     <= '0;
                    r_sof_cnt     <= r_sof_cnt + CW'(1);
                end
                S_WAIT_SOF: begin
                    r_sof_cnt <= r_sof_cnt + CW'(1);
                    r_gap_cnt <= '0;
                end
                S_RECV: begin
                    if (w_abort) begin
                        r_gap_cnt <= r_gap_cnt;
                    end else if (w_eof) begin
                        // A 7-bit short frame is delivered with bit 7 forced low.
                        if (w_short) begin
                            r_byte       <= {1'b0, r_shift[6:0]};
                            r_byte_valid <= 1'b1;
                            r_nbytes     <= 7'd1;
                        end
                    end else if (w_bit) begin
                        r_gap_cnt <= '0;
                        if (!w_parity_slot) begin
                            r_shift[r_bitcnt[2:0]] <= in_bit;
                            r_bitcnt               <= r_bitcnt + 4'd1;
                        end else if (!w_overflow) begin
                            r_byte        <= r_shift;
                            r_byte_valid  <= 1'b1;
                            r_byte_perr   <= w_perr;
                            r_perr_sticky <= r_perr_sticky | w_perr;
                            r_bitcnt      <= 4'd0;
                            r_nbytes      <= r_nbytes + 7'd1;
                        end
                    end else if (r_gap_cnt != GAP_LIM) begin
                        r_gap_cnt <= r_gap_cnt + GW'(1);
                    end
                end
                default: begin
                    r_sof_cnt <= '0;
                end
            endcase
        end
    end

    assign out_chain_rst  = r_chain_rst;
    assign out_chain_en   = r_chain_en;
    assign out_byte       = r_byte;
    assign out_byte_valid = r_byte_valid;
    assign out_byte_perr  = r_byte_perr;
    assign out_busy       = r_busy;
    assign out_done       = r_done;
    assign out_status     = r_status;
    assign out_nbytes     = r_nbytes_out;

endmodule

// File: tb/tb_miller_rx_ctrl.sv
// Scoreboard bench for miller_rx_ctrl: expected bytes and frame results are
// queued as stimulus is driven and compared when the DUT strobes them.
// The DUT works on the falling edge; the bench drives and samples on the rising edge.
module tb_miller_rx_ctrl;

    localparam int SOF_TIMEOUT = 4096;
    localparam int GAP_MAX     = 24;
    localparam int MAX_BYTES   = 64;

    logic       in_clk = 1'b0;
    logic       in_PoR = 1'b1;
    logic       in_start = 1'b0;
    logic       in_abort = 1'b0;
    logic       in_sof_detected = 1'b0;
    logic       in_bit_valid = 1'b0;
    logic       in_bit = 1'b0;
    logic       in_eof_detected = 1'b0;
    logic       out_chain_rst;
    logic       out_chain_en;
    logic [7:0] out_byte;
    logic       out_byte_valid;
    logic       out_byte_perr;
    logic       out_busy;
    logic       out_done;
    logic [2:0] out_status;
    logic [6:0] out_nbytes;

    miller_rx_ctrl #(
        .SOF_TIMEOUT(SOF_TIMEOUT),
        .GAP_MAX    (GAP_MAX),
        .MAX_BYTES  (MAX_BYTES),
        .CW         (13)
    ) dut (
        .in_clk         (in_clk),
        .in_PoR         (in_PoR),
        .in_start       (in_start),
        .in_abort       (in_abort),
        .in_sof_detected(in_sof_detected),
        .in_bit_valid   (in_bit_valid),
        .in_bit         (in_bit),
        .in_eof_detected(in_eof_detected),
        .out_chain_rst  (out_chain_rst),
        .out_chain_en   (out_chain_en),
        .out_byte       (out_byte),
        .out_byte_valid (out_byte_valid),
        .out_byte_perr  (out_byte_perr),
        .out_busy       (out_busy),
        .out_done       (out_done),
        .out_status     (out_status),
        .out_nbytes     (out_nbytes)
    );

    always #5 in_clk = ~in_clk;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int exp_done = 0;
    int cyc      = 0;
    int arm_cyc  = 0;
    int done_cyc = 0;
    int sof_cyc  = 0;
    logic busy_q = 1'b0;

    logic [8:0] byte_q[$];   // {perr, byte}
    logic [9:0] frame_q[$];  // {status, nbytes}
    logic [8:0] mon_b;
    logic [9:0] mon_f;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: pops the scoreboard on every byte strobe and frame-done strobe.
    always @(posedge in_clk) begin
        cyc++;
        if (out_busy && !busy_q) arm_cyc = cyc;
        busy_q = out_busy;
        if (out_byte_valid) begin
            check_val("byte_expected", byte_q.size() != 0, 1);
            if (byte_q.size() != 0) begin
                mon_b = byte_q.pop_front();
                check_val("byte", out_byte, mon_b[7:0]);
                check_val("byte_perr", out_byte_perr, mon_b[8]);
            end
        end
        if (out_done) begin
            done_cnt++;
            done_cyc = cyc;
            check_val("done_expected", frame_q.size() != 0, 1);
            if (frame_q.size() != 0) begin
                mon_f = frame_q.pop_front();
                check_val("status", out_status, mon_f[9:7]);
                check_val("nbytes", out_nbytes, mon_f[6:0]);
            end
            check_val("done_chain_en", out_chain_en, 0);
            check_val("done_busy", out_busy, 0);
        end
    end

    task automatic start_frame();
        @(posedge in_clk); in_start = 1'b1;
        @(posedge in_clk); in_start = 1'b0;
    endtask

    task automatic give_sof();
        @(posedge in_clk); in_sof_detected = 1'b1;
        #1 sof_cyc = cyc;
    endtask

    task automatic send_bit(input logic b);
        @(posedge in_clk); in_bit_valid = 1'b1; in_bit = b;
        @(posedge in_clk); in_bit_valid = 1'b0; in_bit = 1'b0;
    endtask

    task automatic send_bits(input logic [7:0] v, input int n);
        for (int i = 0; i < n; i++) send_bit(v[i]);
    endtask

    // Eight data bits LSB first, then the parity bit; queue the strobe if one is due.
    task automatic send_byte(input logic [7:0] v, input logic p, input bit expect_strobe);
        logic [8:0] all;
        logic       perr_e;
        all    = {p, v};
        perr_e = (($countones(all) % 2) == 0);
        send_bits(v, 8);
        if (expect_strobe) byte_q.push_back({perr_e, v});
        send_bit(p);
    endtask

    function automatic logic odd_par(input logic [7:0] v);
        return (($countones(v) % 2) == 0);
    endfunction

    task automatic expect_frame(input logic [2:0] st, input logic [6:0] nb);
        frame_q.push_back({st, nb});
        exp_done++;
    endtask

    task automatic send_eof();
        @(posedge in_clk); in_eof_detected = 1'b1;
        @(posedge in_clk); in_eof_detected = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k;
        k = 0;
        while (done_cnt < exp_done && k < budget) begin
            @(posedge in_clk); #1;
            k++;
        end
        check_val("done_within_budget", done_cnt >= exp_done, 1);
        in_sof_detected = 1'b0;
        @(posedge in_clk);
    endtask

    initial begin
        int base;
        // Reset state
        repeat (3) @(posedge in_clk);
        #1;
        check_val("rst_chain_rst", out_chain_rst, 0);
        check_val("rst_chain_en", out_chain_en, 0);
        check_val("rst_busy", out_busy, 0);
        check_val("rst_done", out_done, 0);
        check_val("rst_byte_valid", out_byte_valid, 0);
        check_val("rst_status", out_status, 0);
        check_val("rst_nbytes", out_nbytes, 0);
        @(posedge in_clk); in_PoR = 1'b0;

        // Reset in the middle of RECV after 5 bits
        start_frame();
        give_sof();
        send_bits(8'h15, 5);
        @(posedge in_clk); in_PoR = 1'b1;
        @(posedge in_clk); in_PoR = 1'b0; in_sof_detected = 1'b0;
        #1;
        check_val("midrst_busy", out_busy, 0);
        check_val("midrst_byte_valid", out_byte_valid, 0);
        check_val("midrst_chain_rst", out_chain_rst, 0);
        base = done_cnt;
        repeat (8) @(posedge in_clk);
        #1 check_val("midrst_no_done", done_cnt - base, 0);

        // Single byte 0xA5 with good parity
        start_frame();
        @(posedge in_clk); #1;
        check_val("wait_chain_rst", out_chain_rst, 1);
        check_val("wait_chain_en", out_chain_en, 1);
        check_val("wait_busy", out_busy, 1);
        give_sof();
        send_byte(8'hA5, 1'b1, 1);
        expect_frame(3'd0, 7'd1);
        send_eof();
        wait_done(50);

        // Two bytes, second with bad parity
        start_frame();
        give_sof();
        send_byte(8'h26, 1'b0, 1);
        send_byte(8'h00, 1'b0, 1);
        expect_frame(3'd2, 7'd2);
        send_eof();
        wait_done(50);

        // Short 7-bit frame
        start_frame();
        give_sof();
        byte_q.push_back({1'b0, 8'h26});
        send_bits(8'h26, 7);
        expect_frame(3'd1, 7'd1);
        send_eof();
        wait_done(50);

        // Ten bits then EoF: incomplete
        start_frame();
        give_sof();
        send_byte(8'hC3, odd_par(8'hC3), 1);
        send_bit(1'b1);
        expect_frame(3'd3, 7'd1);
        send_eof();
        wait_done(50);

        // No SoF: timeout SOF_TIMEOUT clocks after ARM
        start_frame();
        expect_frame(3'd5, 7'd0);
        wait_done(SOF_TIMEOUT + 50);
        check_val("sof_timeout_latency", done_cyc - arm_cyc, SOF_TIMEOUT);

        // SoF then silence: gap timeout
        start_frame();
        give_sof();
        expect_frame(3'd6, 7'd0);
        wait_done(100);
        check_val("gap_not_early", (done_cyc - sof_cyc) > GAP_MAX, 1);

        // Abort in WAIT_SOF; status of the previous frame must hold
        start_frame();
        repeat (3) @(posedge in_clk);
        @(posedge in_clk); in_abort = 1'b1;
        @(posedge in_clk); in_abort = 1'b0;
        #1;
        check_val("abort_busy", out_busy, 0);
        base = done_cnt;
        repeat (10) @(posedge in_clk);
        #1;
        check_val("abort_no_done", done_cnt - base, 0);
        check_val("status_hold", out_status, 6);

        // Bit strobe coincident with EoF after one full byte: bit dropped
        start_frame();
        give_sof();
        send_byte(8'h5A, odd_par(8'h5A), 1);
        expect_frame(3'd0, 7'd1);
        @(posedge in_clk); in_bit_valid = 1'b1; in_bit = 1'b1; in_eof_detected = 1'b1;
        @(posedge in_clk); in_bit_valid = 1'b0; in_bit = 1'b0; in_eof_detected = 1'b0;
        wait_done(50);

        // Overflow: the byte after MAX_BYTES ends the frame without a strobe
        start_frame();
        give_sof();
        expect_frame(3'd4, 7'(MAX_BYTES));
        for (int i = 0; i < MAX_BYTES; i++) begin
            logic [7:0] v;
            v = 8'(i) ^ 8'h3C;
            send_byte(v, odd_par(v), 1);
        end
        send_byte(8'h81, odd_par(8'h81), 0);
        wait_done(50);

        // Fresh frame still works after everything
        start_frame();
        give_sof();
        send_byte(8'hA5, 1'b1, 1);
        expect_frame(3'd0, 7'd1);
        send_eof();
        wait_done(50);

        repeat (4) @(posedge in_clk);
        #1;
        check_val("byte_q_drained", byte_q.size(), 0);
        check_val("frame_q_drained", frame_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
